audio_stream_feeder: RTL

- Upstream stage of the codec unit. Accepts 64-bit AXI4-Stream stereo sample words from the DMA path and buffers them in an internal FIFO.
- Releases exactly one 48-bit stereo sample per sample_tick onto the codec unit's data_in/data_wr interface.
- Handles priming, underrun (zero-fill plus count), and flush on disable, so the codec always receives one write per frame.

---
 rtl/audio_stream_feeder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/audio_stream_feeder.sv
// Stream-to-codec feeder: buffers 64-bit AXIS stereo words and hands exactly one
// 48-bit sample to the codec per sample_tick. Covers priming, underrun zero-fill and flush.
module audio_stream_feeder #(
  parameter int FIFO_DEPTH  = 16,
  parameter int PRIME_LEVEL = 8,
  parameter int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             board_clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic [63:0]      s_axis_tdata,
  input  logic             sample_tick,
  output logic [47:0]      data_in,
  output logic             data_wr,
  output logic [LVL_W-1:0] fifo_level,
  output logic [15:0]      underrun_count,
  output logic             running
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ST_DISABLED = 2'd0;
  localparam logic [1:0] ST_PRIMING  = 2'd1;
  localparam logic [1:0] ST_RUNNING  = 2'd2;

  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LVL_PRIME = LVL_W'(PRIME_LEVEL);

  // Handshake: a word moves on any cycle where s_axis_tvalid && s_axis_tready;
  // the master keeps tdata stable while tvalid is high and tready is low.

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [15:0]      underrun_count_q, underrun_count_d;
  logic [47:0]      data_in_q, data_in_d;
  logic             data_wr_q, data_wr_d;
  logic             running_q, running_d;
  logic [63:0]      mem_q [FIFO_DEPTH];

  logic        push;
  logic        pop;
  logic        tick_act;
  logic        underrun;
  logic [63:0] rd_word;

  assign s_axis_tready = enable && (level_q < LVL_FULL);
  assign push          = s_axis_tvalid && s_axis_tready;
  assign tick_act      = sample_tick && enable && (state_q != ST_DISABLED);
  assign pop           = tick_act && (state_q == ST_RUNNING) && (level_q != '0);
  assign underrun      = tick_act && (state_q == ST_RUNNING) && (level_q == '0);
  assign rd_word       = mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_DISABLED;
    end else begin
      case (state_q)
        ST_DISABLED: state_d = ST_PRIMING;
        // A tick in the cycle that reaches the prime level is still a zero write.
        ST_PRIMING:  if (level_q >= LVL_PRIME) state_d = ST_RUNNING;
        ST_RUNNING:  if (underrun) state_d = ST_PRIMING;
        default:     state_d = ST_DISABLED;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (!enable) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_comb begin
    data_wr_d        = tick_act;
    data_in_d        = data_in_q;
    underrun_count_d = underrun_count_q;
    running_d        = (state_d == ST_RUNNING);
    // Keep the top 24 bits of each 32-bit lane; the low byte is dropped.
    if (tick_act) data_in_d = pop ? {rd_word[31:8], rd_word[63:40]} : '0;
    if (underrun && (underrun_count_q != 16'hFFFF)) underrun_count_d = underrun_count_q + 16'd1;
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_DISABLED;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      level_q          <= '0;
      underrun_count_q <= '0;
      data_in_q        <= '0;
      data_wr_q        <= 1'b0;
      running_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      level_q          <= level_d;
      underrun_count_q <= underrun_count_d;
      data_in_q        <= data_in_d;
      data_wr_q        <= data_wr_d;
      running_q        <= running_d;
    end
  end

  always_ff @(posedge board_clk) begin
    if (push) mem_q[wr_ptr_q] <= s_axis_tdata;
  end

  assign data_in        = data_in_q;
  assign data_wr        = data_wr_q;
  assign fifo_level     = level_q;
  assign underrun_count = underrun_count_q;
  assign running        = running_q;

endmodule
